// File: rtl/char_conv.sv
// MIX CHAR datapath: sequential double-dabble of a 30-bit magnitude into ten MIX digit codes.
// Define CHAR_CONV_FAST_EN to run two correct+shift steps per cycle (latency 16 instead of 31).
module char_conv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [29:0] in,
    output logic [59:0] out,
    output logic        stop
);

    localparam int unsigned BIN_W  = 30;
    localparam int unsigned DIGITS = 10;
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned CODE_W = 6;
    localparam int unsigned OUT_W  = CODE_W * DIGITS;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned ACC_W  = BCD_W + BIN_W;
`ifdef CHAR_CONV_FAST_EN
    localparam int unsigned STEPS  = 2;
`else
    localparam int unsigned STEPS  = 1;
`endif
    localparam int unsigned CNT_DONE = BIN_W / STEPS;

    logic              run_q,  run_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic [BIN_W-1:0]  bin_q,  bin_d;
    logic [BCD_W-1:0]  bcd_q,  bcd_d;
    logic [OUT_W-1:0]  out_q,  out_d;
    logic              stop_q, stop_d;
    logic [ACC_W-1:0]  acc;

    // One double-dabble step: bias every nibble >= 5 by 3, then shift {bcd,bin} left.
    function automatic logic [ACC_W-1:0] dd_step(input logic [ACC_W-1:0] v);
        logic [ACC_W-1:0] t;
        t = v;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (t[BIN_W + 4*i +: 4] >= 4'd5) begin
                t[BIN_W + 4*i +: 4] = t[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        return {t[ACC_W-2:0], 1'b0};
    endfunction

    // Digit-to-character mapping is a 6-bit add of the MIX code for "0".
    function automatic logic [OUT_W-1:0] to_codes(input logic [BCD_W-1:0] b);
        logic [OUT_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            r[CODE_W*i +: CODE_W] = 6'd30 + {2'b00, b[4*i +: 4]};
        end
        return r;
    endfunction

    always_comb begin
        run_d  = run_q;
        cnt_d  = cnt_q;
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        out_d  = out_q;
        stop_d = 1'b0;
        acc    = {bcd_q, bin_q};
        if (start) begin
            // A start always wins, aborting any conversion in flight.
            run_d = 1'b1;
            cnt_d = '0;
            bin_d = in;
            bcd_d = '0;
        end else if (run_q) begin
            for (int unsigned s = 0; s < STEPS; s++) begin
                acc = dd_step(acc);
            end
            bcd_d = acc[ACC_W-1:BIN_W];
            bin_d = acc[BIN_W-1:0];
            cnt_d = cnt_q + 5'd1;
            if (cnt_d == CNT_W'(CNT_DONE)) begin
                run_d  = 1'b0;
                stop_d = 1'b1;
                out_d  = to_codes(acc[ACC_W-1:BIN_W]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            bin_q  <= '0;
            bcd_q  <= '0;
            out_q  <= '0;
            stop_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            out_q  <= out_d;
            stop_q <= stop_d;
        end
    end

    assign out  = out_q;
    assign stop = stop_q;

endmodule

// File: doc/char_conv.md
Name: char_conv

Overview:
- Executes MIX CHAR, opcode 5(1): converts the 30-bit magnitude of rA into ten MIX character codes, digits "0".."9" = codes 30..39, for loading into rA:rX.
- Inverse of the NUM datapath. Sits beside it in the opcode-5 execution unit and uses the same start/stop pulse handshake toward the sequencer.
- Sequential double-dabble: one binary bit per cycle, then digit-to-character mapping on the output register.

Parameters:
- none; widths are fixed by the MIX word format of 5 bytes x 6 bits.

Ports:
- clk    input   1   system clock, rising edge
- rst_n  input   1   asynchronous, active-low reset
- start  input   1   one-cycle pulse; samples `in` and begins conversion
- in     input   30  rA magnitude, bytes 1..5; sign is handled by the sequencer
- out    output  60  {rA[1:5], rX[1:5]}; most significant digit code in out[59:54], least in out[5:0]
- stop   output  1   one-cycle pulse: conversion complete, `out` valid

Behaviour:
- Reset (rst_n low, asynchronous): run=0, step counter=0, bin shift register=0, BCD register (40 bits)=0, out=60'd0, stop=0.
- Clock numbering: cycle 0 is the cycle in which start=1, sampled at edge E1.
- At E1: bin<=in, bcd<=0, cnt<=0, run<=1.
- Each edge E2..E31 while run=1, one step:
  - correct: each BCD nibble >=5 gets +3;
  - shift: {bcd,bin} shift left 1;
  - cnt<=cnt+1.
- At the edge where cnt reaches 30 (E31):
  - run<=0, stop<=1;
  - out<=packed codes, each 6-bit field = 6'd30 + {2'b00, nibble}, i.e. a 6-bit add, never concatenation.
  - stop is high for cycle 31 only. Latency from start to stop is 31 cycles.
- out holds its value until the next completion or reset. It does not change during a conversion.
- Range:
  - the 30-bit maximum 1073741823 fits 10 digits, so no overflow is possible;
  - every nibble stays 0..9, so each code is 30..39;
  - leading zeros are emitted as code 30.
- start while run=1: abort and restart with the new `in`. No stop is issued for the aborted conversion; stop follows 31 cycles after the latest start.
- start in the same cycle as stop: stop still pulses for the completed conversion, and the new conversion begins.
- rst_n asserted mid-conversion: everything clears immediately, no stop follows, out=0.
- stop is never asserted while run=0 except in the completion cycle itself.

Optional Feature:
- Macro CHAR_CONV_FAST_EN.
- Defined:
  - each cycle performs two chained correct+shift steps;
  - completion when cnt reaches 15;
  - stop at cycle 16, latency 16;
  - all other rules are unchanged, including abort, reset and out hold.
- Undefined: one step per cycle, latency 31 as specified above.
- Output values are identical in both builds.

Test Plan:
- in=0 -> stop in cycle 31; out = ten fields of 30, i.e. 60'h79E79E79E79E79E (011110 repeated).
- in=12977700 -> fields 30,30,31,32,39,37,37,37,30,30 ("0012977700"), stop a single pulse.
- in=30'h3FFFFFFF (1073741823) -> fields 31,30,37,33,37,34,31,38,32,33. Check no nibble exceeds 9 at any step.
- start with in=5, then start with in=123 ten cycles later -> exactly one stop, 31 cycles after the second start; out = "0000000123" (30,...,30,31,32,33).
- Complete a conversion of 42, then start with in=7 and pull rst_n low at cycle 12 -> out=0 and stop=0 immediately. No stop appears within 40 following cycles. A fresh start then works normally.
- With CHAR_CONV_FAST_EN: repeat the 12977700 and maximum-value cases -> identical out, stop in cycle 16.
